// File: rtl/endpoint_tx_loader.sv
// endpoint_tx_loader: loads one outbound message into a chiplet endpoint.
// Programs the packet-start register and streams the payload words into
// the TX cache, then writes the message ID to the send register.
module endpoint_tx_loader #(
   parameter int NUM_MSGS        = 4,
   parameter int CACHE_NUM_WORDS = 128,
   parameter int ADDR_WIDTH      = $clog2(4*CACHE_NUM_WORDS)
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               req_valid,
   output logic                               req_ready,
   input  logic [$clog2(NUM_MSGS)-1:0]        req_msg_id,
   input  logic [$clog2(CACHE_NUM_WORDS)-1:0] req_start_word,
   input  logic [$clog2(CACHE_NUM_WORDS):0]   req_len,
   input  logic                               data_valid,
   output logic                               data_ready,
   input  logic [31:0]                        data,
   output logic [31:0]                        bus_addr,
   output logic                               bus_wen,
   output logic                               bus_ren,
   output logic [31:0]                        bus_wdata,
   output logic [3:0]                         bus_strobe,
   input  logic [31:0]                        bus_rdata,
   input  logic                               bus_error,
   input  logic                               bus_request_stall,
   output logic                               busy,
   output logic                               done,
   output logic                               err
);

   localparam int ID_W = $clog2(NUM_MSGS);
   localparam int SW   = $clog2(CACHE_NUM_WORDS);
   localparam int LW   = SW + 1;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_SET_ADDR = 3'd1,
      ST_LOAD     = 3'd2,
      ST_SEND     = 3'd3,
      ST_DONE     = 3'd4
   } state_t;

   state_t          state_q, state_d;
   logic [ID_W-1:0] id_q, id_d;
   logic [SW-1:0]   start_q, start_d;
   logic [LW-1:0]   len_q, len_d;
   logic [LW-1:0]   i_q, i_d;

   logic            complete_s;
   logic            req_bad_s;
   logic            err_s;
   logic [SW+1:0]   end_word_s;
   logic            unused_rdata;

   // The read data path is never used by a write-only manager.
   assign unused_rdata = ^bus_rdata;

   // Request range check, done one bit wider than the length so it cannot wrap.
   always_comb begin
      end_word_s = {2'b00, req_start_word} + {1'b0, req_len};
      req_bad_s  = (end_word_s > (SW+2)'(CACHE_NUM_WORDS)) ||
                   ({1'b0, req_msg_id} >= (ID_W+1)'(NUM_MSGS));
   end

   // Bus and handshake outputs decoded from the current state.
   always_comb begin
      bus_addr   = 32'h0000_0000;
      bus_wdata  = 32'h0000_0000;
      bus_wen    = 1'b0;
      data_ready = 1'b0;
      case (state_q)
         ST_SET_ADDR: begin
            bus_wen   = 1'b1;
            bus_addr  = 32'({id_q, 2'b00});
            bus_wdata = 32'(ADDR_WIDTH'({start_q, 2'b00}));
         end
         ST_LOAD: begin
            bus_wen    = data_valid;
            bus_addr   = 32'h0000_2000 + ((32'(start_q) + 32'(i_q)) << 2);
            bus_wdata  = data;
            data_ready = data_valid && !bus_request_stall;
         end
         ST_SEND: begin
            bus_wen   = 1'b1;
            bus_addr  = 32'h0000_1004;
            bus_wdata = 32'(id_q);
         end
         default: begin
            bus_wen = 1'b0;
         end
      endcase
      complete_s = bus_wen && !bus_request_stall;
      bus_ren    = 1'b0;
      bus_strobe = bus_wen ? 4'hF : 4'h0;
      req_ready  = (state_q == ST_IDLE);
      busy       = (state_q != ST_IDLE);
      done       = (state_q == ST_DONE);
      err        = err_s;
   end

   // Next-state and request-register update.
   always_comb begin
      state_d = state_q;
      id_d    = id_q;
      start_d = start_q;
      len_d   = len_q;
      i_d     = i_q;
      err_s   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               id_d    = req_msg_id;
               start_d = req_start_word;
               len_d   = req_len;
               i_d     = {LW{1'b0}};
               if (req_bad_s) begin
                  err_s = 1'b1;
               end else begin
                  state_d = ST_SET_ADDR;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SET_ADDR: begin
            if (complete_s && bus_error) begin
               err_s   = 1'b1;
               state_d = ST_IDLE;
            end else if (complete_s) begin
               state_d = (len_q == {LW{1'b0}}) ? ST_SEND : ST_LOAD;
            end else begin
               state_d = ST_SET_ADDR;
            end
         end
         ST_LOAD: begin
            if (complete_s && bus_error) begin
               err_s   = 1'b1;
               state_d = ST_IDLE;
            end else if (complete_s) begin
               i_d = i_q + LW'(1);
               if (i_q == len_q - LW'(1)) begin
                  state_d = ST_SEND;
               end else begin
                  state_d = ST_LOAD;
               end
            end else begin
               state_d = ST_LOAD;
            end
         end
         ST_SEND: begin
            if (complete_s && bus_error) begin
               err_s   = 1'b1;
               state_d = ST_IDLE;
            end else if (complete_s) begin
               state_d = ST_DONE;
            end else begin
               state_d = ST_SEND;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and request registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         id_q    <= {ID_W{1'b0}};
         start_q <= {SW{1'b0}};
         len_q   <= {LW{1'b0}};
         i_q     <= {LW{1'b0}};
      end else begin
         state_q <= state_d;
         id_q    <= id_d;
         start_q <= start_d;
         len_q   <= len_d;
         i_q     <= i_d;
      end
   end

endmodule
